card_flip_ctrl: RTL and testbench

Game-sequencing controller for the memory-game card layer. It accepts card picks from the mouse/selection logic and turns at most two cards face-up per turn. It compares their pair values, then either locks the pair as matched or holds the mismatched pair visible for a fixed time before hiding it. Its `face_up` vector drives the per-card enable inputs of the card rectangle-drawing stages in the video pipeline; `done` and `moves` feed the score/overlay logic.

---
 rtl/memory_pkg.sv | 20 ++
 rtl/hold_timer.sv | 34 +++
 rtl/card_flip_ctrl.sv | 164 ++++++++++++++++
 tb/tb_card_flip_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// memory_pkg: shared constants and types for the memory-game card layer.
//   - N_CARDS, IDX_W, VAL_W: default board geometry
//   - HOLD_1S_65MHZ: one second of pclk at 65 MHz
//   - state_e: card_flip_ctrl sequencing states
package memory_pkg;

    localparam int unsigned N_CARDS       = 16;
    localparam int unsigned IDX_W         = 5;
    localparam int unsigned VAL_W         = 3;
    localparam int unsigned HOLD_1S_65MHZ = 65_000_000;

    typedef enum logic [2:0] {
        WAIT_FIRST  = 3'd0,
        WAIT_SECOND = 3'd1,
        COMPARE     = 3'd2,
        HOLD        = 3'd3,
        DONE        = 3'd4
    } state_e;

endpackage

// File: rtl/hold_timer.sv
// hold_timer: loadable down-counter with a zero flag, usable for any game timeout.
// Ports:
//   pclk       - clock
//   rst        - synchronous active-high clear (counter to 0)
//   i_load     - load i_load_val (has priority over counting)
//   i_load_val - value to load
//   i_en       - decrement by one per cycle while nonzero
//   o_zero     - counter currently equals 0
module hold_timer #(
    parameter int unsigned CNT_W = 26
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/card_flip_ctrl.sv
// card_flip_ctrl: turns at most two cards face-up per turn, matches or hides them.
// Ports:
//   pclk, rst        - clock, synchronous active-high reset
//   new_game         - synchronous restart, same effect as rst
//   pick_valid/idx   - single-cycle card pick
//   card_val         - packed pair values, card i at [i*VAL_W +: VAL_W]
//   face_up, matched - per-card shown / permanently matched
//   busy             - comparing or holding a mismatch; picks ignored
//   match_p, miss_p  - one-cycle result pulses
//   moves            - completed turns, saturating at 255
//   done             - whole board matched
module card_flip_ctrl #(
    parameter int unsigned N_CARDS     = 16,
    parameter int unsigned IDX_W       = 5,
    parameter int unsigned VAL_W       = 3,
    parameter int unsigned HOLD_CYCLES = 65_000_000
) (
    input  logic                     pclk,
    input  logic                     rst,
    input  logic                     new_game,
    input  logic                     pick_valid,
    input  logic [IDX_W-1:0]         pick_idx,
    input  logic [N_CARDS*VAL_W-1:0] card_val,
    output logic [N_CARDS-1:0]       face_up,
    output logic [N_CARDS-1:0]       matched,
    output logic                     busy,
    output logic                     match_p,
    output logic                     miss_p,
    output logic [7:0]               moves,
    output logic                     done
);

    import memory_pkg::*;

    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_e             r_state;
    logic [IDX_W-1:0]   r_first;
    logic [IDX_W-1:0]   r_second;
    logic [N_CARDS-1:0] r_face_up;
    logic [N_CARDS-1:0] r_matched;
    logic               r_busy;
    logic               r_match_p;
    logic               r_miss_p;
    logic [7:0]         r_moves;
    logic               r_done;

    logic               w_rst;
    logic               w_pick_ok;
    logic [N_CARDS-1:0] w_pick_oh;
    logic [N_CARDS-1:0] w_first_oh;
    logic [N_CARDS-1:0] w_second_oh;
    logic [VAL_W-1:0]   w_val_a;
    logic [VAL_W-1:0]   w_val_b;
    logic               w_equal;
    logic               w_tmr_zero;

    assign w_rst = rst | new_game;

    // One-hot masks via shifts: out-of-range indices simply give an empty mask.
    assign w_pick_oh   = N_CARDS'(1) << pick_idx;
    assign w_first_oh  = N_CARDS'(1) << r_first;
    assign w_second_oh = N_CARDS'(1) << r_second;

    assign w_pick_ok = pick_valid && (32'(pick_idx) < N_CARDS) &&
                       ((r_face_up & w_pick_oh) == '0);

    always_comb begin
        w_val_a = '0;
        w_val_b = '0;
        for (int i = 0; i < int'(N_CARDS); i++) begin
            if (32'(r_first) == i)  w_val_a = card_val[i*VAL_W +: VAL_W];
            if (32'(r_second) == i) w_val_b = card_val[i*VAL_W +: VAL_W];
        end
    end

    assign w_equal = (w_val_a == w_val_b);

    hold_timer #(
        .CNT_W (CNT_W)
    ) u_hold_timer (
        .pclk       (pclk),
        .rst        (w_rst),
        .i_load     ((r_state == COMPARE) && !w_equal),
        .i_load_val (HOLD_LOAD),
        .i_en       (r_state == HOLD),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge pclk) begin
        if (w_rst) begin
            r_state   <= WAIT_FIRST;
            r_first   <= '0;
            r_second  <= '0;
            r_face_up <= '0;
            r_matched <= '0;
            r_busy    <= 1'b0;
            r_match_p <= 1'b0;
            r_miss_p  <= 1'b0;
            r_moves   <= '0;
            r_done    <= 1'b0;
        end else begin
            r_match_p <= 1'b0;
            r_miss_p  <= 1'b0;
            case (r_state)
                WAIT_FIRST: begin
                    if (w_pick_ok) begin
                        r_face_up <= r_face_up | w_pick_oh;
                        r_first   <= pick_idx;
                        r_state   <= WAIT_SECOND;
                    end
                end
                WAIT_SECOND: begin
                    if (w_pick_ok) begin
                        r_face_up <= r_face_up | w_pick_oh;
                        r_second  <= pick_idx;
                        if (r_moves != 8'hFF) r_moves <= r_moves + 8'd1;
                        r_busy    <= 1'b1;
                        r_state   <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (w_equal) begin
                        r_matched <= r_matched | w_first_oh | w_second_oh;
                        r_match_p <= 1'b1;
                        r_busy    <= 1'b0;
                        if ((r_matched | w_first_oh | w_second_oh) == {N_CARDS{1'b1}}) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_state <= WAIT_FIRST;
                        end
                    end else begin
                        r_miss_p <= 1'b1;
                        r_state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (w_tmr_zero) begin
                        r_face_up <= r_face_up & ~(w_first_oh | w_second_oh);
                        r_busy    <= 1'b0;
                        r_state   <= WAIT_FIRST;
                    end
                end
                DONE: begin
                    // Board complete: hold everything until restart.
                end
                default: begin
                    r_state <= WAIT_FIRST;
                end
            endcase
        end
    end

    assign face_up = r_face_up;
    assign matched = r_matched;
    assign busy    = r_busy;
    assign match_p = r_match_p;
    assign miss_p  = r_miss_p;
    assign moves   = r_moves;
    assign done    = r_done;

endmodule

// File: tb/tb_card_flip_ctrl.sv
// tb_card_flip_ctrl: directed test of card_flip_ctrl on a 4-card board, HOLD_CYCLES=4.
module tb_card_flip_ctrl;

    localparam int unsigned NC = 4;
    localparam int unsigned IW = 5;
    localparam int unsigned VW = 3;
    localparam int unsigned HC = 4;

    logic             pclk = 1'b0;
    logic             rst = 1'b1;
    logic             new_game = 1'b0;
    logic             pick_valid = 1'b0;
    logic [IW-1:0]    pick_idx = '0;
    // card3=1, card2=0, card1=1, card0=0
    logic [NC*VW-1:0] card_val = {3'd1, 3'd0, 3'd1, 3'd0};
    logic [NC-1:0]    face_up;
    logic [NC-1:0]    matched;
    logic             busy;
    logic             match_p;
    logic             miss_p;
    logic [7:0]       moves;
    logic             done;

    int n_total = 0;
    int n_pass  = 0;

    card_flip_ctrl #(
        .N_CARDS     (NC),
        .IDX_W       (IW),
        .VAL_W       (VW),
        .HOLD_CYCLES (HC)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .new_game   (new_game),
        .pick_valid (pick_valid),
        .pick_idx   (pick_idx),
        .card_val   (card_val),
        .face_up    (face_up),
        .matched    (matched),
        .busy       (busy),
        .match_p    (match_p),
        .miss_p     (miss_p),
        .moves      (moves),
        .done       (done)
    );

    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic pick(input int idx);
        pick_valid = 1'b1;
        pick_idx   = IW'(idx);
        tick();
        pick_valid = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".face_up"}, 32'(face_up), 32'h0);
        chk({tag, ".matched"}, 32'(matched), 32'h0);
        chk({tag, ".busy"},    32'(busy),    32'h0);
        chk({tag, ".match_p"}, 32'(match_p), 32'h0);
        chk({tag, ".miss_p"},  32'(miss_p),  32'h0);
        chk({tag, ".moves"},   32'(moves),   32'h0);
        chk({tag, ".done"},    32'(done),    32'h0);
    endtask

    initial begin
        // Reset
        tick();
        tick();
        rst = 1'b0;
        chk_idle("reset");
        pick(0);
        chk("first_pick.face_up", 32'(face_up), 32'h1);
        chk("first_pick.busy", 32'(busy), 32'h0);

        // Illegal picks
        pick(0);
        chk("repick.face_up", 32'(face_up), 32'h1);
        chk("repick.moves", 32'(moves), 32'h0);
        pick(7);
        chk("range.face_up", 32'(face_up), 32'h1);
        chk("range.moves", 32'(moves), 32'h0);
        chk("range.busy", 32'(busy), 32'h0);

        // Match 0/2
        pick(2);
        chk("match.k.face_up", 32'(face_up), 32'h5);
        chk("match.k.busy", 32'(busy), 32'h1);
        chk("match.k.moves", 32'(moves), 32'h1);
        chk("match.k.match_p", 32'(match_p), 32'h0);
        chk("match.k.matched", 32'(matched), 32'h0);
        tick();
        chk("match.k1.match_p", 32'(match_p), 32'h1);
        chk("match.k1.matched", 32'(matched), 32'h5);
        chk("match.k1.busy", 32'(busy), 32'h0);
        chk("match.k1.done", 32'(done), 32'h0);
        tick();
        chk("match.k2.match_p", 32'(match_p), 32'h0);
        pick(2);
        chk("matched_repick.face_up", 32'(face_up), 32'h5);
        chk("matched_repick.busy", 32'(busy), 32'h0);

        // Completion 1/3
        pick(1);
        pick(3);
        chk("compl.k.face_up", 32'(face_up), 32'hF);
        chk("compl.k.moves", 32'(moves), 32'h2);
        tick();
        chk("compl.done", 32'(done), 32'h1);
        chk("compl.matched", 32'(matched), 32'hF);
        chk("compl.match_p", 32'(match_p), 32'h1);
        pick(0);
        tick();
        chk("compl.after.moves", 32'(moves), 32'h2);
        chk("compl.after.done", 32'(done), 32'h1);
        chk("compl.after.match_p", 32'(match_p), 32'h0);
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        chk_idle("new_game");

        // Mismatch 0/1, pick during HOLD and at HOLD exit dropped
        pick(0);
        pick(1);
        chk("miss.k.face_up", 32'(face_up), 32'h3);
        chk("miss.k.busy", 32'(busy), 32'h1);
        chk("miss.k.moves", 32'(moves), 32'h1);
        chk("miss.k.miss_p", 32'(miss_p), 32'h0);
        for (int i = 1; i <= 5; i++) begin
            if (i == 2) begin
                pick(3);
            end else if (i == 5) begin
                pick(2);
            end else begin
                tick();
            end
            if (i <= 4) begin
                chk($sformatf("miss.k%0d.face_up", i), 32'(face_up), 32'h3);
                chk($sformatf("miss.k%0d.busy", i), 32'(busy), 32'h1);
                chk($sformatf("miss.k%0d.miss_p", i), 32'(miss_p), (i == 1) ? 32'h1 : 32'h0);
            end else begin
                chk("miss.exit.face_up", 32'(face_up), 32'h0);
                chk("miss.exit.busy", 32'(busy), 32'h0);
                chk("miss.exit.moves", 32'(moves), 32'h1);
                chk("miss.exit.matched", 32'(matched), 32'h0);
            end
        end
        // Next pick after exit is accepted
        pick(2);
        chk("post_hold.face_up", 32'(face_up), 32'h4);

        // Restart mid-HOLD
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        pick(0);
        pick(1);
        tick();
        tick();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        chk_idle("midhold");
        for (int i = 0; i < 6; i++) tick();
        chk("midhold.late.face_up", 32'(face_up), 32'h0);
        chk("midhold.late.busy", 32'(busy), 32'h0);
        pick(1);
        chk("midhold.pick.face_up", 32'(face_up), 32'h2);
        chk("midhold.pick.moves", 32'(moves), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
